// File: rtl/cpu.sv
// rtl/cpu.sv - multi-cycle 16-bit load/store CPU with 16-entry register file
module cpu #(
    parameter int WIDTH   = 16,
    parameter int IMM     = 8,
    parameter int REG_ADD = 4,
    parameter int PSRL    = 5
) (
    input  logic             clk50MHz,
    input  logic             reset,
    input  logic [WIDTH-1:0] mem_out,
    output logic             memwrite,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] writedata
);

    localparam int NREG = 1 << REG_ADD;

    localparam logic [2:0] FETCH   = 3'b000;
    localparam logic [2:0] DECODE  = 3'b001;
    localparam logic [2:0] EXECUTE = 3'b010;
    localparam logic [2:0] MEMRD   = 3'b011;
    localparam logic [2:0] MEMWR   = 3'b100;

    localparam logic [3:0] OP_REG   = 4'b0000;
    localparam logic [3:0] OP_LDST  = 4'b0100;
    localparam logic [3:0] EXT_LOAD = 4'b0000;
    localparam logic [3:0] EXT_STOR = 4'b0100;

    // Register-form ext codes and immediate-form opcodes share one encoding
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_ADD = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b1001;
    localparam logic [3:0] ALU_CMP = 4'b1011;
    localparam logic [3:0] ALU_MOV = 4'b1101;

    localparam int PSR_N = 4;
    localparam int PSR_Z = 3;
    localparam int PSR_F = 2;
    localparam int PSR_L = 1;
    localparam int PSR_C = 0;

    logic [2:0]       state_q, state_d, state;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic [PSRL-1:0]  psr_q, psr_d;

    logic [3:0]         opcode, ext;
    logic [REG_ADD-1:0] rd, rs;
    logic [IMM-1:0]     imm;

    assign state  = state_q;
    assign opcode = ir_q[15:12];
    assign rd     = ir_q[11:8];
    assign ext    = ir_q[7:4];
    assign rs     = ir_q[3:0];
    assign imm    = ir_q[IMM-1:0];

    logic [3:0]       alu_op;
    logic             alu_valid, alu_wr;
    logic [WIDTH-1:0] alu_b, alu_res;
    logic [WIDTH:0]   sum, diff;
    logic [PSRL-1:0]  alu_psr;

    // ALU: operand select, result and flag update for the decoded instruction
    always_comb begin
        alu_op = (opcode == OP_REG) ? ext : opcode;
        if (opcode == OP_REG)
            alu_b = opb_q;
        else if (alu_op == ALU_ADD || alu_op == ALU_SUB || alu_op == ALU_CMP)
            alu_b = {{(WIDTH-IMM){imm[IMM-1]}}, imm};
        else
            alu_b = {{(WIDTH-IMM){1'b0}}, imm};
        sum       = {1'b0, opa_q} + {1'b0, alu_b};
        diff      = {1'b0, opa_q} - {1'b0, alu_b};
        alu_valid = 1'b1;
        alu_wr    = 1'b1;
        alu_res   = '0;
        alu_psr   = psr_q;
        case (alu_op)
            ALU_AND: alu_res = opa_q & alu_b;
            ALU_OR:  alu_res = opa_q | alu_b;
            ALU_XOR: alu_res = opa_q ^ alu_b;
            ALU_MOV: alu_res = alu_b;
            ALU_ADD: begin
                alu_res        = sum[WIDTH-1:0];
                alu_psr[PSR_C] = sum[WIDTH];
                alu_psr[PSR_F] = (opa_q[WIDTH-1] == alu_b[WIDTH-1]) &&
                                 (sum[WIDTH-1] != opa_q[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res        = diff[WIDTH-1:0];
                alu_psr[PSR_C] = diff[WIDTH];
                alu_psr[PSR_F] = (opa_q[WIDTH-1] != alu_b[WIDTH-1]) &&
                                 (diff[WIDTH-1] != opa_q[WIDTH-1]);
            end
            ALU_CMP: begin
                alu_wr         = 1'b0;
                alu_psr[PSR_Z] = (opa_q == alu_b);
                alu_psr[PSR_L] = (opa_q < alu_b);
                alu_psr[PSR_N] = ($signed(opa_q) < $signed(alu_b));
            end
            default: begin
                alu_valid = 1'b0;
                alu_wr    = 1'b0;
            end
        endcase
    end

    // Sequencer: next-state, register/PSR writes and memory port drive
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        regs_d    = regs_q;
        psr_d     = psr_q;
        mem_addr  = pc_q;
        memwrite  = 1'b0;
        writedata = '0;
        case (state)
            FETCH: begin
                ir_d    = mem_out;
                state_d = DECODE;
            end
            DECODE: begin
                opa_d   = regs_q[rd];
                opb_d   = regs_q[rs];
                state_d = EXECUTE;
            end
            EXECUTE: begin
                if (opcode == OP_LDST && ext == EXT_LOAD) begin
                    state_d = MEMRD;
                end else if (opcode == OP_LDST && ext == EXT_STOR) begin
                    state_d = MEMWR;
                end else begin
                    if (alu_wr)
                        regs_d[rd] = alu_res;
                    if (alu_valid)
                        psr_d = alu_psr;
                    pc_d    = pc_q + WIDTH'(1);
                    state_d = FETCH;
                end
            end
            MEMRD: begin
                mem_addr   = opb_q;
                regs_d[rd] = mem_out;
                pc_d       = pc_q + WIDTH'(1);
                state_d    = FETCH;
            end
            MEMWR: begin
                mem_addr  = opb_q;
                writedata = opa_q;
                memwrite  = 1'b1;
                pc_d      = pc_q + WIDTH'(1);
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Architectural and pipeline state; reset aborts any instruction in flight
    always_ff @(posedge clk50MHz or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            psr_q   <= '0;
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            psr_q   <= psr_d;
            regs_q  <= regs_d;
        end
    end

endmodule

// File: tb/tb_cpu.sv
// tb/tb_cpu.sv - table-driven program check of the cpu block
module tb_cpu;

    logic        clk50MHz = 1'b0;
    logic        reset    = 1'b0;
    logic [15:0] mem_out;
    logic        memwrite;
    logic [15:0] mem_addr;
    logic [15:0] writedata;

    logic [15:0] mem [0:255];

    assign mem_out = mem[mem_addr[7:0]];

    cpu dut (
        .clk50MHz (clk50MHz),
        .reset    (reset),
        .mem_out  (mem_out),
        .memwrite (memwrite),
        .mem_addr (mem_addr),
        .writedata(writedata)
    );

    always #10 clk50MHz = ~clk50MHz;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // kind: 0 = three-cycle ALU/move/NOP, 1 = LOAD, 2 = STOR
    typedef struct {
        logic [15:0] instr;
        int          kind;
        int          rd;
        logic [15:0] rval;
        logic [4:0]  psr;
    } vec_t;

    localparam int NV = 33;
    vec_t vecs [NV];

    initial begin
        vecs[0]  = '{16'hD105, 0, 1, 16'h0005, 5'h00}; // MOVI 5,r1
        vecs[1]  = '{16'h02D1, 0, 2, 16'h0005, 5'h00}; // MOV r1,r2
        vecs[2]  = '{16'h0251, 0, 2, 16'h000A, 5'h00}; // ADD r1,r2
        vecs[3]  = '{16'h0192, 0, 1, 16'hFFFB, 5'h01}; // SUB r2,r1 -> borrow
        vecs[4]  = '{16'hD950, 0, 9, 16'h0050, 5'h01}; // MOVI 0x50,r9
        vecs[5]  = '{16'h4409, 1, 4, 16'h7FFF, 5'h01}; // LOAD r4,[r9]
        vecs[6]  = '{16'h5401, 0, 4, 16'h8000, 5'h04}; // ADDI 1 -> overflow
        vecs[7]  = '{16'h54FF, 0, 4, 16'h7FFF, 5'h05}; // ADDI -1 -> carry+overflow
        vecs[8]  = '{16'hD4FF, 0, 4, 16'h00FF, 5'h05}; // MOVI zero-extends
        vecs[9]  = '{16'h34FF, 0, 4, 16'h0000, 5'h05}; // XORI
        vecs[10] = '{16'h54FF, 0, 4, 16'hFFFF, 5'h00}; // ADDI -1 on 0
        vecs[11] = '{16'h5401, 0, 4, 16'h0000, 5'h01}; // ADDI 1 on FFFF -> carry
        vecs[12] = '{16'hD951, 0, 9, 16'h0051, 5'h01};
        vecs[13] = '{16'h4209, 1, 2, 16'h1234, 5'h01}; // LOAD r2,[r9]
        vecs[14] = '{16'hD340, 0, 3, 16'h0040, 5'h01};
        vecs[15] = '{16'h4243, 2, 2, 16'h1234, 5'h01}; // STOR r2,[r3]
        vecs[16] = '{16'h4503, 1, 5, 16'h1234, 5'h01}; // LOAD r5,[r3]
        vecs[17] = '{16'h9601, 0, 6, 16'hFFFF, 5'h01}; // SUBI 1 on 0
        vecs[18] = '{16'hD703, 0, 7, 16'h0003, 5'h01};
        vecs[19] = '{16'h07B6, 0, 7, 16'h0003, 5'h03}; // CMP r6,r7
        vecs[20] = '{16'hB703, 0, 7, 16'h0003, 5'h09}; // CMPI 3 -> Z
        vecs[21] = '{16'hB7FF, 0, 7, 16'h0003, 5'h03}; // CMPI -1
        vecs[22] = '{16'h27F0, 0, 7, 16'h00F3, 5'h03}; // ORI
        vecs[23] = '{16'h0731, 0, 7, 16'hFF08, 5'h03}; // XOR r1,r7
        vecs[24] = '{16'h170F, 0, 7, 16'h0008, 5'h03}; // ANDI
        vecs[25] = '{16'h0000, 0, 0, 16'h0000, 5'h03}; // NOP (reg ext 0)
        vecs[26] = '{16'hF123, 0, 1, 16'hFFFB, 5'h03}; // NOP (opcode F)
        vecs[27] = '{16'h0353, 0, 3, 16'h0080, 5'h02}; // ADD r3,r3 doubles
        vecs[28] = '{16'hD0AB, 0, 0, 16'h00AB, 5'h02}; // r0 writable
        vecs[29] = '{16'h01B7, 0, 1, 16'hFFFB, 5'h10}; // CMP r7,r1 -> N
        vecs[30] = '{16'hD950, 0, 9, 16'h0050, 5'h10};
        vecs[31] = '{16'h4809, 1, 8, 16'h7FFF, 5'h10}; // LOAD r8,[r9]
        vecs[32] = '{16'h98FF, 0, 8, 16'h8000, 5'h15}; // SUBI -1 -> overflow+borrow

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        for (int i = 0; i < NV; i++) mem[i] = vecs[i].instr;
        mem[8'h50] = 16'h7FFF;
        mem[8'h51] = 16'h1234;

        // Reset state
        reset = 1'b0;
        repeat (2) @(posedge clk50MHz);
        #1;
        check("rst state", 16'(dut.state_q), 16'h0000);
        check("rst mem_addr", mem_addr, 16'h0000);
        check("rst memwrite", 16'(memwrite), 16'h0000);
        check("rst writedata", writedata, 16'h0000);
        check("rst psr", 16'(dut.psr_q), 16'h0000);
        check("rst ir", dut.ir_q, 16'h0000);
        check("rst r15", dut.regs_q[15], 16'h0000);
        @(negedge clk50MHz);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            int ncyc;
            ncyc = (vecs[i].kind == 0) ? 3 : 4;
            for (int c = 0; c < ncyc; c++) begin
                logic [2:0] es;
                logic       ew;
                @(posedge clk50MHz);
                #1;
                if (c == ncyc - 1)  es = 3'b000;
                else if (c == 0)    es = 3'b001;
                else if (c == 1)    es = 3'b010;
                else                es = (vecs[i].kind == 1) ? 3'b011 : 3'b100;
                ew = (vecs[i].kind == 2) && (c == 2);
                check($sformatf("v%0d state c%0d", i, c), 16'(dut.state_q), 16'(es));
                check($sformatf("v%0d memwrite c%0d", i, c), 16'(memwrite), 16'(ew));
                if (ew) begin
                    check($sformatf("v%0d st addr", i), mem_addr, 16'h0040);
                    check($sformatf("v%0d st data", i), writedata, vecs[i].rval);
                end else begin
                    check($sformatf("v%0d writedata c%0d", i, c), writedata, 16'h0000);
                end
                if (memwrite) mem[mem_addr[7:0]] = writedata;
            end
            check($sformatf("v%0d r%0d", i, vecs[i].rd), dut.regs_q[vecs[i].rd], vecs[i].rval);
            check($sformatf("v%0d psr", i), 16'(dut.psr_q), 16'(vecs[i].psr));
            check($sformatf("v%0d pc", i), mem_addr, 16'(i + 1));
        end

        // Reset mid-program returns to FETCH at address 0 immediately
        @(negedge clk50MHz);
        reset = 1'b0;
        #1;
        check("rst2 state", 16'(dut.state_q), 16'h0000);
        check("rst2 mem_addr", mem_addr, 16'h0000);
        check("rst2 r8", dut.regs_q[8], 16'h0000);
        @(negedge clk50MHz);
        reset = 1'b1;
        repeat (2) @(posedge clk50MHz);
        #1;
        check("abort in execute", 16'(dut.state_q), 16'h0002);
        @(negedge clk50MHz);
        reset = 1'b0;
        #1;
        check("abort state", 16'(dut.state_q), 16'h0000);
        check("abort pc", mem_addr, 16'h0000);
        check("abort psr", 16'(dut.psr_q), 16'h0000);
        @(posedge clk50MHz);
        #1;
        check("abort r1 held", dut.regs_q[1], 16'h0000);
        check("abort state held", 16'(dut.state_q), 16'h0000);
        @(negedge clk50MHz);
        reset = 1'b1;
        @(posedge clk50MHz);
        #1;
        check("refetch ir", dut.ir_q, 16'hD105);
        check("refetch state", 16'(dut.state_q), 16'h0001);
        repeat (2) @(posedge clk50MHz);
        #1;
        check("refetch r1", dut.regs_q[1], 16'h0005);
        check("refetch pc", mem_addr, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
